// File: rtl/left_shift_seq.sv
// left_shift_seq: multi-cycle left shifter/rotator, one power-of-two stage per clock, largest first.
// Optional LSHIFT_EARLY_DONE_EN finishes as soon as no lower count bits remain.
module left_shift_seq #(
   parameter int WIDTH = 16,
   parameter int CNTW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] In,
   input  logic [CNTW-1:0]  Cnt,
   input  logic             Rot,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Out
);
   localparam int KW = (CNTW > 1) ? $clog2(CNTW) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_n;
   logic [KW-1:0] k;
   logic [WIDTH-1:0] work, out_r, stage;
   logic [CNTW-1:0] cnt_r, amt;
   logic rot_r, accept, last;
   logic [2*WIDTH-1:0] dbl;
   assign accept = start && state != SHIFT;
   assign busy = state == SHIFT;
   assign done = state == DONE;
   assign Out = out_r;
   assign amt = CNTW'(1) << k;
   // Rotation falls out of the upper half of the doubled word shifted left.
   assign dbl = {work, work} << amt;
   assign stage = cnt_r[k] ? (rot_r ? dbl[2*WIDTH-1:WIDTH] : work << amt) : work;
`ifdef LSHIFT_EARLY_DONE_EN
   logic [CNTW-1:0] low_mask;
   assign low_mask = amt - CNTW'(1);
   assign last = (cnt_r & low_mask) == '0;
`else
   assign last = k == '0;
`endif
   always_comb begin
      state_n = state;
      if (state == SHIFT) state_n = last ? DONE : SHIFT;
      else if (start) state_n = SHIFT;
      else state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k     <= KW'(CNTW-1);
         work  <= '0;
         cnt_r <= '0;
         rot_r <= 1'b0;
         out_r <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            work  <= In;
            cnt_r <= Cnt;
            rot_r <= Rot;
            k     <= KW'(CNTW-1);
         end else if (state == SHIFT) begin
            work <= stage;
            k    <= k - KW'(1);
            if (last) out_r <= stage;
         end
      end
   end
endmodule

// File: tb/tb_left_shift_seq.sv
// tb_left_shift_seq: scoreboard bench for left_shift_seq; results and latencies checked on each done pulse.
module tb_left_shift_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, Rot = 1'b0;
   logic [15:0] In = '0;
   logic [3:0] Cnt = '0;
   logic busy, done;
   logic [15:0] Out;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic [15:0] last_out = '0;
   typedef struct {logic [15:0] v; int a; int lat;} exp_t;
   exp_t q[$];

   left_shift_seq dut (.clk(clk), .rst(rst), .start(start), .In(In), .Cnt(Cnt), .Rot(Rot),
                       .busy(busy), .done(done), .Out(Out));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] v, input int c, input logic r);
      logic [15:0] res;
      res = v << c;
      if (r) res = res | (v >> (16 - c));
      return res;
   endfunction

   function automatic int lat_of(input int c);
`ifdef LSHIFT_EARLY_DONE_EN
      int lo;
      lo = 3;
      for (int i = 3; i >= 0; i--) if (c[i]) lo = i;
      return 4 - lo + 1;
`else
      return 5;
`endif
   endfunction

   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) chk("spurious_done", 32'(done), 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("out", 32'(Out), 32'(e.v));
            chk("latency", cyc - e.a + 1, e.lat);
            chk("busy_in_done", 32'(busy), 32'd0);
            last_out = e.v;
         end
      end
   end

   // Called at a negedge; waits for busy=0, then issues one request.
   task automatic op(input logic [15:0] v, input logic [3:0] c, input logic r, input bit push);
      int w;
      w = 0;
      while (busy && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) chk("busy_timeout", 32'(busy), 32'd0);
      In = v; Cnt = c; Rot = r; start = 1'b1;
      if (push) q.push_back('{model(v, int'(c), r), cyc + 1, lat_of(int'(c))});
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("out_hold", 32'(Out), 32'(last_out));
   endtask

   initial begin
      int w;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_out", 32'(Out), 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      op(16'h8421, 4'd4, 1'b0, 1);
      @(negedge clk);
      start = 1'b1; In = 16'h0001; Cnt = 4'd1; Rot = 1'b0;
      @(negedge clk);
      start = 1'b0;
      op(16'h8421, 4'd4, 1'b1, 1);
      op(16'h1234, 4'd8, 1'b1, 1);
      op(16'hFFFF, 4'd15, 1'b0, 1);
      op(16'h0001, 4'd1, 1'b0, 1);
      op(16'hBEEF, 4'd0, 1'b1, 1);
      op(16'h0003, 4'd12, 1'b1, 1);
      op(16'h00FF, 4'd5, 1'b0, 1);
      w = 0;
      while (q.size() > 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      op(16'h00FF, 4'd3, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_out = '0;
      chk("midrst_out", 32'(Out), 32'h0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      repeat (6) @(negedge clk);
      op(16'h00FF, 4'd3, 1'b0, 1);
      for (int i = 0; i < 24; i++) begin
         op(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      w = 0;
      while (q.size() > 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain", q.size(), 32'd0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
